dot_accum: RTL

//  Downstream consumer of the 8x8 Wallace-tree multiplier product (mul[15:0]).

---
 rtl/dot_accum.sv | 76 +++++++
 1 files changed

// File: rtl/dot_accum.sv
// Dot-product accumulator behind the 8x8 multiplier.
// Sums LEN unsigned products and holds the result on a valid/ready port.
module dot_accum #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int LEN    = 8,
  localparam int CW    = (LEN < 2) ? 1 : $clog2(LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              ovf,
  output logic [CW-1:0]     count
);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] DONE  = 1'b1;

  localparam logic [CW-1:0] LAST = CW'(LEN - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [0:0]      state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;
  logic             take;
  logic             drain;

  assign sum = {1'b0, acc}
             + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign acc_out   = acc;

  assign take  = in_ready & in_valid;
  assign drain = out_valid & out_ready;

  // clr outranks both a transfer and a drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      acc   <= '0;
      ovf   <= 1'b0;
      count <= '0;
    end else if (clr) begin
      state <= ACCUM;
      acc   <= '0;
      ovf   <= 1'b0;
      count <= '0;
    end else begin
      unique case (1'b1)
        take: begin
          acc   <= sum[ACC_W-1:0];
          ovf   <= ovf | sum[ACC_W];
          count <= count + ONE;
          if (count == LAST)
            state <= DONE;
        end
        drain: begin
          state <= ACCUM;
          acc   <= '0;
          ovf   <= 1'b0;
          count <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
